// File: rtl/pcie_fifo_burst_arbiter_pkg.sv
// Shared types and helpers for the PCIe FIFO burst arbiter.
// The optional stall watchdog is enabled with PFA_WDOG_EN.
package pfa_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    XFER = 2'd2
  } state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  localparam int DEF_BURST_LEN = 64;
  localparam int MAX_BURST_LEN = 4096;
  // Widest beat counter any legal BURST_LEN can need.
  localparam int CNT_W = clog2(MAX_BURST_LEN) + 1;

endpackage

// File: rtl/pcie_fifo_burst_arbiter_rr_picker.sv
// Combinational round-robin first-one finder: the first set req bit at or
// above ptr, wrapping at N_CH.
module pfa_rr_picker #(
  parameter int N_CH = 4,
  parameter int CH_W = 2
) (
  input  logic [N_CH-1:0] req,
  input  logic [CH_W-1:0] ptr,
  output logic [CH_W-1:0] gnt_idx,
  output logic            gnt_any
);

  localparam logic [CH_W:0] N_CH_L = (CH_W + 1)'(N_CH);

  always_comb begin
    logic [CH_W:0] idx;
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx     = '0;
    // Walk from the farthest offset down so the closest requester wins.
    for (int i = N_CH - 1; i >= 0; i--) begin
      idx = {1'b0, ptr} + (CH_W + 1)'(i);
      if (idx >= N_CH_L) idx = idx - N_CH_L;
      if (req[idx[CH_W-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = idx[CH_W-1:0];
      end
    end
  end

endmodule

// File: rtl/pcie_fifo_burst_arbiter.sv
// Round-robin burst scheduler sharing one DMA stream between N prefetch FIFOs.
// Define PFA_WDOG_EN to abort bursts that stall for WDOG_CYCLES cycles.
module pcie_fifo_burst_arbiter
  import pfa_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int DATA_W      = 32,
  parameter int BURST_LEN   = DEF_BURST_LEN,
  parameter int CH_W        = 2,
  parameter int WDOG_CYCLES = 1024
) (
  input  logic                   rd_clk,
  input  logic                   rd_rst,
  input  logic                   enable,
  input  logic [N_CH-1:0]        ch_burst_rdy,
  input  logic [N_CH-1:0]        ch_rd_vld,
  input  logic [N_CH*DATA_W-1:0] ch_rd_data,
  output logic [N_CH-1:0]        ch_rd_en,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [DATA_W-1:0]      m_data,
  output logic [CH_W-1:0]        m_ch,
  output logic                   m_sop,
  output logic                   m_eop,
  output logic                   busy,
  output logic                   abort_pulse
);

  localparam int BEAT_W = (clog2(BURST_LEN) + 1 > CNT_W) ? CNT_W : clog2(BURST_LEN) + 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
  localparam logic [CH_W-1:0]   LAST_CH   = CH_W'(N_CH - 1);

  state_e              state_q;
  logic [CH_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [CH_W-1:0]     grant_q;
  logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [N_CH-1:0]     req_q;

  logic [N_CH-1:0]     arb_req;
  logic [CH_W-1:0]     pick_idx;
  logic                pick_any;
  logic                in_xfer, beat, last_beat, wdog_fire;

  // Requests that vanish during ARB fall back to the snapshot taken in IDLE.
  assign arb_req = (|ch_burst_rdy) ? ch_burst_rdy : req_q;

  pfa_rr_picker #(
    .N_CH (N_CH),
    .CH_W (CH_W)
  ) u_picker (
    .req     (arb_req),
    .ptr     (rr_ptr_q),
    .gnt_idx (pick_idx),
    .gnt_any (pick_any)
  );

  always_comb begin
    in_xfer  = (state_q == XFER);
    m_valid  = in_xfer & ch_rd_vld[grant_q];
    m_data   = in_xfer ? ch_rd_data[int'(grant_q)*DATA_W +: DATA_W] : '0;
    ch_rd_en = (in_xfer & m_ready) ? (N_CH'(1) << grant_q) : '0;
  end

  assign beat       = m_valid & m_ready;
  assign last_beat  = beat & (beat_cnt_q == LAST_BEAT);
  assign m_sop      = m_valid & (beat_cnt_q == '0);
  assign m_eop      = m_valid & (beat_cnt_q == LAST_BEAT);
  assign m_ch       = grant_q;
  assign busy       = (state_q != IDLE);
  assign rr_ptr_d   = (grant_q == LAST_CH) ? '0 : grant_q + 1'b1;
  assign beat_cnt_d = beat_cnt_q + 1'b1;

`ifdef PFA_WDOG_EN
  localparam int WDOG_W = clog2(WDOG_CYCLES + 1);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);

  logic [WDOG_W-1:0] wdog_q;
  logic              abort_q;

  assign wdog_fire   = in_xfer & ~beat & (wdog_q == WDOG_LAST);
  assign abort_pulse = abort_q;

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      wdog_q  <= '0;
      abort_q <= 1'b0;
    end else begin
      abort_q <= wdog_fire;
      if (!in_xfer || beat || wdog_fire) wdog_q <= '0;
      else                               wdog_q <= wdog_q + 1'b1;
    end
  end
`else
  logic [31:0] unused_wdog_cycles;
  assign unused_wdog_cycles = 32'(WDOG_CYCLES);
  assign wdog_fire   = 1'b0;
  assign abort_pulse = 1'b0;
`endif

  // NOTE: sequential state is updated only with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      beat_cnt_q <= '0;
      req_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          req_q <= ch_burst_rdy;
          if (enable && |ch_burst_rdy) state_q <= ARB;
        end
        ARB: begin
          if (pick_any) grant_q <= pick_idx;
          beat_cnt_q <= '0;
          state_q    <= XFER;
        end
        XFER: begin
          if (wdog_fire) begin
            rr_ptr_q <= rr_ptr_d;
            state_q  <= IDLE;
          end else if (beat) begin
            beat_cnt_q <= beat_cnt_d;
            if (last_beat) begin
              rr_ptr_q <= rr_ptr_d;
              state_q  <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pcie_fifo_burst_arbiter.sv
// Self-checking bench: FIFO models per channel, burst-level scoreboard and
// round-robin grant model; watchdog steps run when PFA_WDOG_EN is defined.
module tb_pcie_fifo_burst_arbiter;

  localparam int N_CH = 4;
  localparam int DATA_W = 32;
  localparam int BURST_LEN = 64;
  localparam int CH_W = 2;
  localparam int WDOG = 16;

  logic                   rd_clk = 1'b0;
  logic                   rd_rst;
  logic                   enable;
  logic [N_CH-1:0]        ch_burst_rdy, ch_rd_vld, ch_rd_en;
  logic [N_CH*DATA_W-1:0] ch_rd_data;
  logic                   m_valid, m_ready, m_sop, m_eop, busy, abort_pulse;
  logic [DATA_W-1:0]      m_data;
  logic [CH_W-1:0]        m_ch;

  pcie_fifo_burst_arbiter #(
    .N_CH(N_CH), .DATA_W(DATA_W), .BURST_LEN(BURST_LEN), .CH_W(CH_W), .WDOG_CYCLES(WDOG)
  ) dut (
    .rd_clk(rd_clk), .rd_rst(rd_rst), .enable(enable), .ch_burst_rdy(ch_burst_rdy),
    .ch_rd_vld(ch_rd_vld), .ch_rd_data(ch_rd_data), .ch_rd_en(ch_rd_en),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_ch(m_ch),
    .m_sop(m_sop), .m_eop(m_eop), .busy(busy), .abort_pulse(abort_pulse)
  );

  always #5 rd_clk = ~rd_clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int head [N_CH];     // FIFO pops seen per channel
  int exp_idx [N_CH];  // words delivered downstream per channel
  bit in_burst;
  int cur_ch, beat_i, rr_m, cyc, last_eop_cyc, bursts;
  bit gap_chk;
  int grants [$];
  logic [N_CH-1:0] pop_s;

  // Stimulus knobs
  bit rand_ready;
  logic [N_CH-1:0] vld_base;
  int drop_left;
  int en_drop_at;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] word(input int c, input int k);
    return {c[7:0], k[23:0]};
  endfunction

  function automatic int pick(input logic [N_CH-1:0] rdy, input int ptr);
    for (int i = 0; i < N_CH; i++) begin
      int c;
      c = (ptr + i) % N_CH;
      if (rdy[c]) return c;
    end
    return -1;
  endfunction

  task automatic drive_data();
    for (int c = 0; c < N_CH; c++) ch_rd_data[c*DATA_W +: DATA_W] = word(c, head[c]);
  endtask

  task automatic observe();
    int bi, eg;
    logic ok;
    pop_s = ch_rd_en & ch_rd_vld;
    ok = (ch_rd_en == '0) || (m_ready && ch_rd_en == (4'b0001 << m_ch));
    check("rd_en_legal", ok, 1'b1);
    if (!busy) check("idle_quiet", {m_valid, ch_rd_en}, '0);
`ifndef PFA_WDOG_EN
    check("abort_tied", abort_pulse, 1'b0);
`endif
    if (in_burst) begin
      check("valid_track", m_valid, ch_rd_vld[cur_ch]);
      check("rd_en_track", ch_rd_en, m_ready ? (4'b0001 << cur_ch) : 4'b0000);
    end
    if (m_valid) begin
      bi = in_burst ? beat_i : 0;
      check("sop", m_sop, bi == 0);
      check("eop", m_eop, bi == BURST_LEN - 1);
      if (!in_burst) begin
        eg = pick(ch_burst_rdy, rr_m);
        check("grant", m_ch, eg);
      end
      if (m_ready) begin
        if (!in_burst) begin
          eg = pick(ch_burst_rdy, rr_m);
          cur_ch = (eg < 0) ? int'(m_ch) : eg;
          in_burst = 1;
          beat_i = 0;
          grants.push_back(int'(m_ch));
          if (gap_chk && last_eop_cyc >= 0) check("gap", cyc - last_eop_cyc, 3);
        end
        check("data", m_data, word(cur_ch, exp_idx[cur_ch]));
        exp_idx[cur_ch]++;
        if (beat_i == BURST_LEN - 1) begin
          in_burst = 0;
          rr_m = (cur_ch + 1) % N_CH;
          last_eop_cyc = cyc;
          bursts++;
        end else begin
          beat_i++;
        end
      end
    end else begin
      check("sop_idle", m_sop, 1'b0);
      check("eop_idle", m_eop, 1'b0);
    end
  endtask

  task automatic step();
    @(negedge rd_clk);
    observe();
    @(posedge rd_clk);
    for (int c = 0; c < N_CH; c++) if (pop_s[c]) head[c]++;
    #1;
    cyc++;
    drive_data();
  endtask

  task automatic knobs();
    m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    ch_rd_vld = vld_base;
    if (drop_left > 0 && in_burst && cur_ch == 1 && beat_i >= 20) begin
      ch_rd_vld[1] = 1'b0;
      drop_left--;
    end
    if (en_drop_at >= 0 && in_burst && beat_i >= en_drop_at) enable = 1'b0;
  endtask

  task automatic run_bursts(input int n, input int budget);
    int start, k;
    start = bursts;
    k = 0;
    while (bursts < start + n && k < budget) begin
      knobs();
      step();
      k++;
    end
    check("burst_budget", bursts - start, n);
  endtask

  task automatic run_to_beat(input int b, input int budget);
    int k;
    k = 0;
    while (!(in_burst && beat_i == b) && k < budget) begin
      knobs();
      step();
      k++;
    end
    check("reach_beat", beat_i, b);
  endtask

  task automatic outputs_zero(input string tag);
    check(tag, {ch_rd_en, m_valid, m_sop, m_eop, busy, abort_pulse, m_ch, m_data}, '0);
  endtask

  // Called at posedge+1; reset is asserted and released away from the edges.
  task automatic pulse_reset();
    #1 rd_rst = 1'b1;
    #1 outputs_zero("async_reset");
    #1 rd_rst = 1'b0;
    in_burst = 0;
    rr_m = 0;
    last_eop_cyc = -1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "global timeout");
  end

  initial begin
    int h0 [N_CH];
    int base;
    rd_rst = 1'b1; enable = 1'b0; ch_burst_rdy = '0; ch_rd_vld = '0; m_ready = 1'b0;
    for (int c = 0; c < N_CH; c++) begin head[c] = 0; exp_idx[c] = 0; end
    in_burst = 0; cur_ch = 0; beat_i = 0; rr_m = 0; cyc = 0; last_eop_cyc = -1; bursts = 0;
    gap_chk = 0; rand_ready = 0; vld_base = '0; drop_left = 0; en_drop_at = -1;
    drive_data();
    @(posedge rd_clk); #1;
    outputs_zero("reset_state");
    rd_rst = 1'b0;

    // 1: single requester, latency and one full burst
    enable = 1'b1; ch_burst_rdy = 4'b0100; vld_base = 4'b0100; knobs();
    check("lat_c1", {busy, m_valid}, 2'b00);
    step();
    check("lat_c2", {busy, m_valid}, 2'b10);
    knobs(); step();
    check("lat_c3", {m_valid, m_sop, m_ch}, {1'b1, 1'b1, 2'd2});
    run_bursts(1, 200);
    ch_burst_rdy = '0;
    check("t1_pops", head[2], BURST_LEN);
    check("t1_grant", grants[0], 2);
    step();
    check("t1_idle", busy, 1'b0);

    // 2: all channels ready, round robin from a fresh reset
    pulse_reset();
    for (int c = 0; c < N_CH; c++) h0[c] = head[c];
    ch_burst_rdy = 4'hF; vld_base = 4'hF; gap_chk = 1;
    base = grants.size();
    run_bursts(5, 600);
    ch_burst_rdy = '0; gap_chk = 0;
    for (int i = 0; i < 5; i++) check($sformatf("rr_order%0d", i), grants[base + i], i % N_CH);
    for (int c = 0; c < N_CH; c++)
      check($sformatf("rr_pops%0d", c), head[c] - h0[c], (c == 0) ? 2 * BURST_LEN : BURST_LEN);

    // 3: random back-pressure plus a 10-cycle rd_vld gap on ch1
    h0[1] = head[1];
    ch_burst_rdy = 4'b0010; vld_base = 4'b0010; rand_ready = 1; drop_left = 10;
    run_bursts(1, 800);
    ch_burst_rdy = '0; rand_ready = 0;
    check("t3_pops", head[1] - h0[1], BURST_LEN);
    check("t3_drop_done", drop_left, 0);
    check("t3_grant", grants[grants.size() - 1], 1);

    // 4: enable dropped at beat 30 does not truncate the burst
    ch_burst_rdy = 4'b1001; vld_base = 4'hF; en_drop_at = 30;
    run_bursts(1, 200);
    en_drop_at = -1;
    check("t4_grant", grants[grants.size() - 1], 3);
    check("t4_enable_low", enable, 1'b0);
    for (int i = 0; i < 20; i++) begin
      knobs(); step();
      check("t4_no_arb", busy, 1'b0);
    end
    enable = 1'b1;
    run_bursts(1, 200);
    ch_burst_rdy = '0;
    check("t4_next_grant", grants[grants.size() - 1], 0);

    // 5: reset at beat 20, next grant restarts at channel 0
    ch_burst_rdy = 4'b0100;
    run_to_beat(20, 200);
    pulse_reset();
    ch_burst_rdy = 4'b0101;
    run_bursts(1, 200);
    ch_burst_rdy = '0;
    check("t5_grant", grants[grants.size() - 1], 0);

`ifdef PFA_WDOG_EN
    // 6: watchdog abort after WDOG stall cycles
    begin
      int k;
      pulse_reset();
      ch_burst_rdy = 4'b0011; vld_base = 4'b0001;
      run_to_beat(5, 100);
      vld_base = 4'b0000;
      k = 0;
      while (k < 40) begin
        knobs(); step(); k++;
        if (abort_pulse) break;
      end
      check("wdog_cycles", k, WDOG);
      check("wdog_idle", busy, 1'b0);
      in_burst = 0; rr_m = 1; vld_base = 4'b0011;
      run_bursts(1, 200);
      ch_burst_rdy = '0;
      check("wdog_next_grant", grants[grants.size() - 1], 1);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pcie_fifo_burst_arbiter.md
Name: pcie_fifo_burst_arbiter

Overview:
Round-robin burst scheduler that shares one PCIe DMA stream port between N read-side prefetch FIFOs, one per video channel.
- Grants one channel at a time for a fixed burst of BURST_LEN words.
- Drives the granted FIFO's rd_en and forwards its rd_vld/rd_data onto a valid/ready master stream.
- Marks the first word of a burst with m_sop and the last with m_eop, and tags every word with the channel index.
- Sits between the hdmi_pcie prefetch FIFOs and the PCIe DMA packetizer, in the rd_clk domain.

Parameters:
- N_CH, 4, number of requesting FIFOs (2..8).
- DATA_W, 32, FIFO read data width.
- BURST_LEN, 64, words per granted burst (2..4096).
- CH_W, 2, channel index width; must equal clog2(N_CH).
- WDOG_CYCLES, 1024, stall limit in cycles. Used only with PFA_WDOG_EN.

Ports:
- rd_clk  in  1  clock for all logic.
- rd_rst  in  1  reset: asynchronous, active-high.
- enable  in  1  allows new grants; sampled only in IDLE.
- ch_burst_rdy  in  N_CH  per channel: the FIFO holds ≥BURST_LEN words (water-level flag).
- ch_rd_vld  in  N_CH  per-channel FIFO rd_vld.
- ch_rd_data  in  N_CH*DATA_W  packed FIFO rd_data; channel i occupies bits [i*DATA_W +: DATA_W].
- ch_rd_en  out  N_CH  per-channel FIFO rd_en, which acts as the pop.
- m_valid  out  1  output word valid.
- m_ready  in  1  downstream ready.
- m_data  out  DATA_W  output word.
- m_ch  out  CH_W  channel of the current burst.
- m_sop  out  1  first word of the burst.
- m_eop  out  1  last word of the burst.
- busy  out  1  high while in ARB or XFER.
- abort_pulse  out  1  one-cycle pulse on watchdog abort; tied 0 without PFA_WDOG_EN.

Behaviour:
- Reset values: state=IDLE, rr_ptr=0, grant=0, beat_cnt=0. All outputs are 0: ch_rd_en, m_valid, m_sop, m_eop, busy, abort_pulse, m_ch.
- States:
  - IDLE: if enable and |ch_burst_rdy, go to ARB.
  - ARB: one cycle. Grant the first set bit of ch_burst_rdy scanning from rr_ptr upward, with wrap. Register grant and m_ch. Clear beat_cnt. Go to XFER.
  - XFER: transfer beats as defined below. On the last beat, rr_ptr ← grant+1 (mod N_CH) and go to IDLE.
- Latency: ch_burst_rdy high in IDLE gives the first m_valid in the 3rd cycle (IDLE→ARB→XFER).
- A request that drops during ARB is still granted; the burst then waits on rd_vld.
- XFER datapath is combinational from the granted channel:
  - m_valid = ch_rd_vld[grant].
  - m_data = slice[grant].
  - ch_rd_en[grant] = m_ready.
  - All other ch_rd_en are 0.
  - A beat is m_valid & m_ready; beat_cnt increments on each beat.
- m_sop = m_valid & (beat_cnt==0). m_eop = m_valid & (beat_cnt==BURST_LEN-1).
- Last beat = beat with beat_cnt==BURST_LEN-1.
- beat_cnt width is clog2(BURST_LEN)+1 and never wraps within a burst.
- Stalls: ch_rd_vld low mid-burst deasserts m_valid and holds beat_cnt. m_ready low holds everything. The burst always completes BURST_LEN words.
- enable deasserted mid-burst does not truncate the burst; the burst finishes and the block stays in IDLE.
- Outside XFER, ch_rd_en is all-zero. No word is ever popped without a handshake.
- All channels requesting continuously: grant order is 0,1,2,3,0,...
- A single requester is regranted back-to-back, with a 2-cycle gap (IDLE, ARB) between bursts.
- rd_rst mid-burst: immediately returns to reset values. The partial burst is lost and the downstream sees no m_eop.

Optional Feature:
- PFA_WDOG_EN defined:
  - A counter increments in XFER every cycle with no beat and clears on each beat.
  - On reaching WDOG_CYCLES: abort_pulse=1 for one cycle, go to IDLE, rr_ptr ← grant+1.
  - The downstream discards a packet that lacks m_eop.
- Undefined: no counter, abort_pulse tied 0, XFER waits indefinitely.

Decomposition:
- Package pfa_pkg holds:
  - state enum {IDLE, ARB, XFER};
  - the clog2 function;
  - localparam CNT_W.
- One sub-module, pfa_rr_picker: combinational round-robin first-one finder. Inputs are req[N_CH] and ptr; outputs are gnt_idx and gnt_any.

Test Plan:
1. Reset, then ch_burst_rdy=4'b0100, ch2 rd_vld=1, m_ready=1, BURST_LEN=64 → m_valid from cycle 3; 64 beats tagged m_ch=2; m_sop on beat 0, m_eop on beat 63; ch_rd_en[2] only; return to IDLE.
2. All four channels ready continuously → bursts granted in order 0,1,2,3,0; a 2-cycle gap between bursts; exactly 64 pops per channel per burst.
3. m_ready toggled with a random 50% pattern and ch1 rd_vld dropped for 10 cycles mid-burst → exactly 64 beats; no pop while m_ready=0; beat_cnt holds during the gap; data order preserved against a scoreboard.
4. enable=0 at beat 30 → burst completes to m_eop at beat 63; no new ARB while enable=0; next grant follows rr_ptr after enable=1.
5. rd_rst asserted at beat 20 → all outputs 0 in the same cycle (asynchronous); after release, the next grant starts from channel 0.
6. PFA_WDOG_EN with WDOG_CYCLES=16: ch0 rd_vld stuck low after beat 5 → abort_pulse at the 16th stall cycle; state IDLE; next grant is ch1 if ch1 is ready.
